// File: rtl/tdm_mux8_1_if.sv
`default_nettype none
// ------------------------------------------------------------------
// tdm_mux8_1_if: parallel-word handshake and serial slot bus (Rev 1.0)
// ------------------------------------------------------------------
interface tdm_mux8_1_if;
  logic       E;
  logic [7:0] D;
  logic       D_valid;
  logic       D_ready;
  logic       I;
  logic [2:0] S;
  logic       I_valid;
  logic       frame_start;
  logic       frame_done;

  modport master (
    output E, D, D_valid,
    input  D_ready, I, S, I_valid, frame_start, frame_done
  );

  modport slave (
    input  E, D, D_valid,
    output D_ready, I, S, I_valid, frame_start, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/tdm_mux8_1.sv
`default_nettype none
// ------------------------------------------------------------------
// tdm_mux8_1: 8-to-1 TDM serializer feeding a 1-to-8 demux (Rev 1.0)
// ------------------------------------------------------------------
module tdm_mux8_1 #(
  parameter int unsigned DIV        = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input wire          clk,
  input wire          rst,
  tdm_mux8_1_if.slave tdm
);
  localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    buf_q, buf_d;
  logic [2:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          i_q, i_d;
  logic          iv_q, iv_d;
  logic          fs_q, fs_d;
  logic          fd_q, fd_d;
  logic [2:0]    w_next_s;

  logic w_last_cycle;
  logic w_ready;
  logic w_accept;

  // The final cycle of slot 7 doubles as an accept window so frames can abut.
  assign w_last_cycle = (state_q == ST_SHIFT) && (s_q == 3'd7) && (cnt_q == CNT_MAX);
  assign w_ready      = tdm.E && ((state_q == ST_IDLE) || w_last_cycle);
  assign w_accept     = tdm.D_valid && w_ready;
  assign w_next_s     = s_q + 3'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    iv_d    = iv_q;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    if (tdm.E) begin
      if (w_accept) begin
        state_d = ST_SHIFT;
        buf_d   = tdm.D;
        s_d     = 3'd0;
        cnt_d   = '0;
        i_d     = tdm.D[0];
        iv_d    = 1'b1;
        fs_d    = 1'b1;
      end else if (state_q == ST_SHIFT) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else if (s_q != 3'd7) begin
          s_d   = w_next_s;
          i_d   = buf_q[w_next_s];
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
          s_d     = 3'd0;
          cnt_d   = '0;
          i_d     = IDLE_LEVEL;
          iv_d    = 1'b0;
          fd_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      s_q     <= 3'd0;
      cnt_q   <= '0;
      i_q     <= IDLE_LEVEL;
      iv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      iv_q    <= iv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign tdm.D_ready     = w_ready;
  assign tdm.I           = i_q;
  assign tdm.S           = s_q;
  assign tdm.I_valid     = iv_q;
  assign tdm.frame_start = fs_q;
  assign tdm.frame_done  = fd_q;
endmodule
`default_nettype wire

// File: tb/tb_tdm_mux8_1.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tdm_mux8_1: scoreboard bench for tdm_mux8_1 at DIV=4 and DIV=1 (Rev 1.0)
// ------------------------------------------------------------------
module tb_tdm_mux8_1;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdm_mux8_1_if bus4 ();
  tdm_mux8_1_if bus1 ();

  tdm_mux8_1 #(.DIV(4), .IDLE_LEVEL(1'b0)) dut4 (.clk(clk), .rst(rst), .tdm(bus4));
  tdm_mux8_1 #(.DIV(1), .IDLE_LEVEL(1'b0)) dut1 (.clk(clk), .rst(rst), .tdm(bus1));

  // Expected {frame_start, I, S} for every enabled cycle with I_valid high.
  logic [4:0] q4[$];
  logic [4:0] q1[$];
  logic [4:0] exp4, exp1;
  logic       e4_prev = 1'b0;
  logic       e1_prev = 1'b0;
  int fd4_cnt = 0, fd4_cyc = 0, iv4_cnt = 0, fs4_cnt = 0;
  int fd1_cnt = 0, iv1_cnt = 0;
  int acc, acc2, fd0, iv0, fs0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus4.frame_done === 1'b1) begin fd4_cnt++; fd4_cyc = cyc; end
    if (bus4.frame_start === 1'b1) fs4_cnt++;
    if (bus4.I_valid === 1'b1) iv4_cnt++;
    if (bus4.I_valid === 1'b1 && e4_prev) begin
      if (q4.size() == 0) begin
        n_total++;
        $display("FAIL dut4 scoreboard: got output S=%0d I=%0b, expected none", bus4.S, bus4.I);
      end else begin
        exp4 = q4.pop_front();
        check("dut4 {fs,I,S}", {27'd0, bus4.frame_start, bus4.I, bus4.S}, {27'd0, exp4});
      end
    end
    e4_prev = bus4.E;
  end

  always @(negedge clk) begin
    if (bus1.frame_done === 1'b1) fd1_cnt++;
    if (bus1.I_valid === 1'b1) iv1_cnt++;
    if (bus1.I_valid === 1'b1 && e1_prev) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL dut1 scoreboard: got output S=%0d I=%0b, expected none", bus1.S, bus1.I);
      end else begin
        exp1 = q1.pop_front();
        check("dut1 {fs,I,S}", {27'd0, bus1.frame_start, bus1.I, bus1.S}, {27'd0, exp1});
      end
    end
    e1_prev = bus1.E;
  end

  task automatic send4(input logic [7:0] d, output int a);
    bit ok = 1'b0;
    a = 0;
    bus4.D = d;
    bus4.D_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus4.D_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus4.D_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL dut4 accept timeout: got no D_ready, expected accept");
    end else begin
      a = cyc;
      for (int n = 0; n < 8; n++)
        for (int k = 0; k < 4; k++)
          q4.push_back({(n == 0 && k == 0), d[n], 3'(n)});
    end
  endtask

  task automatic send1(input logic [7:0] d, output int a);
    bit ok = 1'b0;
    a = 0;
    bus1.D = d;
    bus1.D_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus1.D_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus1.D_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL dut1 accept timeout: got no D_ready, expected accept");
    end else begin
      a = cyc;
      for (int n = 0; n < 8; n++)
        q1.push_back({(n == 0), d[n], 3'(n)});
    end
  endtask

  task automatic wait_idle4();
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (bus4.I_valid === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL dut4 idle timeout: got I_valid=1, expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle1();
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (bus1.I_valid === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL dut1 idle timeout: got I_valid=1, expected 0");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus4.E = 1'b1; bus4.D = 8'h00; bus4.D_valid = 1'b0;
    bus1.E = 1'b1; bus1.D = 8'h00; bus1.D_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset I", bus4.I, 0);
    check("reset S", bus4.S, 0);
    check("reset I_valid", bus4.I_valid, 0);
    check("reset frame_start", bus4.frame_start, 0);
    check("reset frame_done", bus4.frame_done, 0);
    check("reset D_ready dut4", bus4.D_ready, 1);
    check("reset D_ready dut1", bus1.D_ready, 1);

    // Single frame, A5
    fd0 = fd4_cnt;
    send4(8'hA5, acc);
    check("single frame_start", bus4.frame_start, 1);
    check("single first bit", bus4.I, 1);
    wait_idle4();
    check("single done latency", fd4_cyc - acc, 32);
    check("single done count", fd4_cnt - fd0, 1);
    check("single idle I", bus4.I, 0);
    check("single idle S", bus4.S, 0);

    // Back-to-back FF then 00
    fd0 = fd4_cnt; iv0 = iv4_cnt; fs0 = fs4_cnt;
    send4(8'hFF, acc);
    send4(8'h00, acc2);
    check("b2b accept spacing", acc2 - acc, 32);
    wait_idle4();
    check("b2b I_valid cycles", iv4_cnt - iv0, 64);
    check("b2b frame_done count", fd4_cnt - fd0, 1);
    check("b2b frame_start count", fs4_cnt - fs0, 2);

    // Enable stall of 10 cycles mid slot 3 of 08
    send4(8'h08, acc);
    repeat (13) @(posedge clk);
    #1;
    bus4.E = 1'b0;
    check("stall D_ready", bus4.D_ready, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall S", bus4.S, 3);
      check("stall I", bus4.I, 1);
    end
    bus4.E = 1'b1;
    wait_idle4();
    check("stall done latency", fd4_cyc - acc, 42);

    // Reset in slot 5
    fd0 = fd4_cnt;
    send4(8'hC3, acc);
    repeat (21) @(posedge clk);
    #1;
    check("pre-reset S", bus4.S, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst I", bus4.I, 0);
    check("midrst S", bus4.S, 0);
    check("midrst I_valid", bus4.I_valid, 0);
    q4.delete();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst no frame_done", fd4_cnt - fd0, 0);
    send4(8'h81, acc);
    wait_idle4();
    check("post-reset frame_done", fd4_cnt - fd0, 1);

    // DIV=1 with a request raised while busy
    fd0 = fd1_cnt; iv0 = iv1_cnt;
    send1(8'h3C, acc);
    repeat (2) @(posedge clk);
    #1;
    check("div1 S at request", bus1.S, 2);
    bus1.D = 8'h96;
    bus1.D_valid = 1'b1;
    check("div1 busy D_ready", bus1.D_ready, 0);
    send1(8'h96, acc2);
    check("div1 accept spacing", acc2 - acc, 8);
    wait_idle1();
    check("div1 I_valid cycles", iv1_cnt - iv0, 16);
    check("div1 frame_done count", fd1_cnt - fd0, 1);

    check("dut4 queue drained", q4.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
